// File: rtl/conn_ctrl_pkg.sv
// conn_ctrl_pkg: shared types for the connection-manager control-port arbiter
package conn_ctrl_pkg;
    localparam int CTRL_KEY_W = 32;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} conn_ctrl_state_t;
    typedef struct packed {
        logic [CTRL_KEY_W-1:0] key;
        logic                  activate;
    } conn_ctrl_req_t;
endpackage

// File: rtl/conn_ctrl_arbiter_if.sv
// conn_ctrl_arbiter_if: requester-side and manager-side control/response handshakes
interface conn_ctrl_arbiter_if
    import conn_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int KEY_W   = CTRL_KEY_W
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*KEY_W-1:0] req_key;
    logic [NUM_REQ-1:0]       req_activate;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0]       resp_valid;
    logic [NUM_REQ-1:0]       resp_ready;
    logic                     resp_ack;
    logic                     resp_full;
    logic                     resp_timeout;
    logic                     m_ctrl_valid;
    logic [KEY_W-1:0]         m_ctrl_key;
    logic                     m_ctrl_activate;
    logic                     m_ctrl_ready;
    logic                     s_resp_valid;
    logic                     s_resp_ack;
    logic                     s_resp_full;
    logic                     s_resp_ready;
    logic                     stale_drop;
    modport slave (
        input  req_valid, req_key, req_activate, resp_ready, m_ctrl_ready,
               s_resp_valid, s_resp_ack, s_resp_full,
        output req_ready, resp_valid, resp_ack, resp_full, resp_timeout,
               m_ctrl_valid, m_ctrl_key, m_ctrl_activate, s_resp_ready, stale_drop
    );
    modport master (
        output req_valid, req_key, req_activate, resp_ready, m_ctrl_ready,
               s_resp_valid, s_resp_ack, s_resp_full,
        input  req_ready, resp_valid, resp_ack, resp_full, resp_timeout,
               m_ctrl_valid, m_ctrl_key, m_ctrl_activate, s_resp_ready, stale_drop
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting the search at ptr_i
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o
);
    logic          found;
    logic [IW-1:0] j;
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        j         = '0;
        for (int k = 0; k < N; k++) begin
            j = IW'((int'(ptr_i) + k) % N);
            if (!found && req_i[j]) begin
                found     = 1'b1;
                gnt_o[j]  = 1'b1;
                gnt_idx_o = j;
            end
        end
    end
endmodule

// File: rtl/conn_ctrl_arbiter.sv
// conn_ctrl_arbiter: round-robin share of the manager control port, one transaction in flight, with watchdog
module conn_ctrl_arbiter
    import conn_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int KEY_W   = CTRL_KEY_W,
    parameter int TIMEOUT = 255
) (
    input logic clk,
    input logic rst,
    conn_ctrl_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

    conn_ctrl_state_t              state_q;
    conn_ctrl_req_t                req_q;
    logic [IW-1:0]                 rr_ptr_q, rr_ptr_d, gnt_q, gnt_idx;
    logic [NUM_REQ-1:0]            gnt_oh;
    logic [NUM_REQ-1:0][KEY_W-1:0] keys;
    logic [TW-1:0]                 timer_q;
    logic                          ack_q, full_q, to_q, stale_q;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req_i     (bus.req_valid),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (gnt_oh),
        .gnt_idx_o (gnt_idx)
    );

    assign keys                = bus.req_key;
    assign rr_ptr_d            = (gnt_q == IW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
    assign bus.req_ready       = (state_q == IDLE) ? gnt_oh : '0;
    assign bus.resp_valid      = (state_q == RESP) ? NUM_REQ'(1) << gnt_q : '0;
    assign bus.resp_ack        = ack_q;
    assign bus.resp_full       = full_q;
    assign bus.resp_timeout    = to_q;
    assign bus.m_ctrl_valid    = state_q == ISSUE;
    assign bus.m_ctrl_key      = KEY_W'(req_q.key);
    assign bus.m_ctrl_activate = req_q.activate;
    assign bus.s_resp_ready    = state_q == IDLE || state_q == WAIT;
    assign bus.stale_drop      = stale_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            req_q    <= '0;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            timer_q  <= '0;
            ack_q    <= 1'b0;
            full_q   <= 1'b0;
            to_q     <= 1'b0;
            stale_q  <= 1'b0;
        end else begin
            // nobody is waiting for a response while idle, so it can only be stale
            stale_q <= state_q == IDLE && bus.s_resp_valid;
            case (state_q)
                IDLE: if (|bus.req_valid) begin
                    gnt_q          <= gnt_idx;
                    req_q.key      <= CTRL_KEY_W'(keys[gnt_idx]);
                    req_q.activate <= bus.req_activate[gnt_idx];
                    state_q        <= ISSUE;
                end
                ISSUE: if (bus.m_ctrl_ready) begin
                    timer_q <= '0;
                    state_q <= WAIT;
                end
                WAIT: if (bus.s_resp_valid) begin
                    ack_q   <= bus.s_resp_ack;
                    full_q  <= bus.s_resp_full;
                    to_q    <= 1'b0;
                    state_q <= RESP;
                end else if (TIMEOUT != 0 && timer_q == TW'(TIMEOUT - 1)) begin
                    ack_q   <= 1'b0;
                    full_q  <= 1'b0;
                    to_q    <= 1'b1;
                    state_q <= RESP;
                end else begin
                    timer_q <= (timer_q == '1) ? timer_q : timer_q + 1'b1;
                end
                RESP: if (bus.resp_ready[gnt_q]) begin
                    rr_ptr_q <= rr_ptr_d;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
